coll_det_param: RTL and testbench



---
 rtl/coll_det_pkg.sv | 28 ++
 rtl/coll_mul.sv | 13 +
 rtl/coll_det_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_coll_det_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coll_det_pkg.sv
// Shared types and width/latency helpers for the parametrised collision detector.
package coll_det_pkg;

    // Sequencer states: latch -> differences -> per-axis products -> wide products -> decide
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIFF = 3'd1,
        ST_MULV = 3'd2,
        ST_MULP = 3'd3,
        ST_CMP  = 3'd4
    } state_e;

    // Accumulator width for dist2 / vrel2 / dot
    function automatic int pw(input int w);
        return 2 * w + 4;
    endfunction

    // Width of the shared multiplier and of the final products A, B, C
    function automatic int bw(input int w);
        return 4 * w + 8;
    endfunction

    // Accept-to-strobe latency in clock edges
    function automatic int lat(input int d);
        return 3 * d + 5;
    endfunction

endpackage

// File: rtl/coll_mul.sv
// Single-cycle signed BW x BW -> BW multiplier, time-shared by the detector FSM.
// Callers sign- or zero-extend operands so the truncated product is exact.
module coll_mul #(
    parameter int BW = 72
) (
    input  logic signed [BW-1:0] a_i,
    input  logic signed [BW-1:0] b_i,
    output logic signed [BW-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/coll_det_param.sv
// Parametrised sphere-sphere collision detector (2-D or 3-D).
// One shared multiplier is sequenced through DIFF/MULV/MULP/CMP; the result is
// a one-cycle out_rdy strobe with hit/approaching held until the next strobe.
module coll_det_param
    import coll_det_pkg::*;
#(
    parameter int W           = 32,
    parameter int D           = 2,
    parameter bit FUTURE_ONLY = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [D*W-1:0] p1,
    input  logic [D*W-1:0] p2,
    input  logic [D*W-1:0] v1,
    input  logic [D*W-1:0] v2,
    input  logic [W-1:0]   r2,
    input  logic           in_rdy,
    output logic           busy,
    output logic           out_rdy,
    output logic           hit,
    output logic           approaching
);

    localparam int PW  = pw(W);
    localparam int BW  = bw(W);
    localparam int DIW = (D > 1) ? $clog2(D) : 1;

    // Sequencer state and step counters
    state_e          state_q;
    logic [1:0]      sel_q;
    logic [DIW-1:0]  dim_q;

    // Latched request
    logic [D*W-1:0]  p1_q;
    logic [D*W-1:0]  p2_q;
    logic [D*W-1:0]  v1_q;
    logic [D*W-1:0]  v2_q;
    logic [W-1:0]    r2_q;

    // Per-axis differences, W+1 bits so they never overflow
    logic signed [W:0] dp_q [D];
    logic signed [W:0] dv_q [D];

    // Accumulators (dist2/vrel2 are non-negative, dot is signed)
    logic [PW-1:0]        dist2_q;
    logic [PW-1:0]        vrel2_q;
    logic signed [PW-1:0] dot_q;

    // Wide products: A = dist2*vrel2, B = dot*dot, C = vrel2*r2
    logic signed [BW-1:0] a_q;
    logic signed [BW-1:0] b_q;
    logic signed [BW-1:0] c_q;

    // Shared multiplier plumbing
    logic signed [W:0]    dp_sel;
    logic signed [W:0]    dv_sel;
    logic signed [BW-1:0] mul_a;
    logic signed [BW-1:0] mul_b;
    logic signed [BW-1:0] mul_p;
    logic [PW-1:0]        prod_pw;

    // Decision terms
    logic signed [BW-1:0] diff_ab;
    logic                 near_hit;
    logic                 far_hit;
    logic                 use_near;

    coll_mul #(.BW(BW)) u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Per-axis products are at most 2W+2 bits, so the low PW bits keep the sign
    assign prod_pw = mul_p[PW-1:0];

    // Route the shared multiplier operands for the current product step
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        dp_sel = dp_q[dim_q];
        dv_sel = dv_q[dim_q];
        case (state_q)
            ST_MULV: begin
                case (sel_q)
                    2'd0: begin
                        mul_a = {{(BW-W-1){dp_sel[W]}}, dp_sel};
                        mul_b = {{(BW-W-1){dp_sel[W]}}, dp_sel};
                    end
                    2'd1: begin
                        mul_a = {{(BW-W-1){dv_sel[W]}}, dv_sel};
                        mul_b = {{(BW-W-1){dv_sel[W]}}, dv_sel};
                    end
                    2'd2: begin
                        mul_a = {{(BW-W-1){dp_sel[W]}}, dp_sel};
                        mul_b = {{(BW-W-1){dv_sel[W]}}, dv_sel};
                    end
                    default: begin
                        mul_a = '0;
                        mul_b = '0;
                    end
                endcase
            end
            ST_MULP: begin
                case (sel_q)
                    2'd0: begin
                        mul_a = {{(BW-PW){1'b0}}, dist2_q};
                        mul_b = {{(BW-PW){1'b0}}, vrel2_q};
                    end
                    2'd1: begin
                        mul_a = {{(BW-PW){dot_q[PW-1]}}, dot_q};
                        mul_b = {{(BW-PW){dot_q[PW-1]}}, dot_q};
                    end
                    2'd2: begin
                        mul_a = {{(BW-PW){1'b0}}, vrel2_q};
                        mul_b = {{(BW-W){1'b0}}, r2_q};
                    end
                    default: begin
                        mul_a = '0;
                        mul_b = '0;
                    end
                endcase
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // A - B is never negative (Cauchy-Schwarz), so a signed compare is safe
    assign diff_ab  = a_q - b_q;
    assign far_hit  = (diff_ab < c_q);
    assign near_hit = (dist2_q < {{(PW-W){1'b0}}, r2_q});
    assign use_near = (vrel2_q == '0) || (FUTURE_ONLY && !dot_q[PW-1]);

    // Datapath: latch the request, form differences, accumulate, hold wide products
    always_ff @(posedge clock) begin
        case (state_q)
            ST_IDLE: begin
                if (in_rdy) begin
                    p1_q <= p1;
                    p2_q <= p2;
                    v1_q <= v1;
                    v2_q <= v2;
                    r2_q <= r2;
                end
            end
            ST_DIFF: begin
                for (int k = 0; k < D; k++) begin
                    dp_q[k] <= {p1_q[k*W+W-1], p1_q[k*W +: W]} - {p2_q[k*W+W-1], p2_q[k*W +: W]};
                    dv_q[k] <= {v1_q[k*W+W-1], v1_q[k*W +: W]} - {v2_q[k*W+W-1], v2_q[k*W +: W]};
                end
                dist2_q <= '0;
                vrel2_q <= '0;
                dot_q   <= '0;
            end
            ST_MULV: begin
                case (sel_q)
                    2'd0:    dist2_q <= dist2_q + prod_pw;
                    2'd1:    vrel2_q <= vrel2_q + prod_pw;
                    2'd2:    dot_q   <= dot_q + prod_pw;
                    default: dot_q   <= dot_q;
                endcase
            end
            ST_MULP: begin
                case (sel_q)
                    2'd0:    a_q <= mul_p;
                    2'd1:    b_q <= mul_p;
                    2'd2:    c_q <= mul_p;
                    default: c_q <= c_q;
                endcase
            end
            default: begin
                a_q <= a_q;
            end
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            dim_q       <= '0;
            busy        <= 1'b0;
            out_rdy     <= 1'b0;
            hit         <= 1'b0;
            approaching <= 1'b0;
        end else begin
            out_rdy <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_rdy) begin
                        busy    <= 1'b1;
                        state_q <= ST_DIFF;
                    end
                end
                ST_DIFF: begin
                    sel_q   <= 2'd0;
                    dim_q   <= '0;
                    state_q <= ST_MULV;
                end
                ST_MULV: begin
                    if (sel_q == 2'd2) begin
                        sel_q <= 2'd0;
                        if (dim_q == DIW'(D-1)) begin
                            dim_q   <= '0;
                            state_q <= ST_MULP;
                        end else begin
                            dim_q <= dim_q + DIW'(1);
                        end
                    end else begin
                        sel_q <= sel_q + 2'd1;
                    end
                end
                ST_MULP: begin
                    if (sel_q == 2'd2) begin
                        sel_q   <= 2'd0;
                        state_q <= ST_CMP;
                    end else begin
                        sel_q <= sel_q + 2'd1;
                    end
                end
                ST_CMP: begin
                    hit         <= use_near ? near_hit : far_hit;
                    approaching <= dot_q[PW-1];
                    out_rdy     <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coll_det_param.sv
// Self-checking bench for coll_det_param: two W=16/D=2 instances (FUTURE_ONLY 0 and 1)
// sharing one stimulus bus, plus a W=32/D=3 instance, all against a closest-approach model.
module tb_coll_det_param;

    typedef logic signed [255:0] big_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] p1_a = '0, p2_a = '0, v1_a = '0, v2_a = '0;
    logic [15:0] r2_a = '0;
    logic        in_rdy_a = 1'b0;
    logic        busy0, ordy0, hit0, app0;
    logic        busy1, ordy1, hit1, app1;

    logic [95:0] p1_b = '0, p2_b = '0, v1_b = '0, v2_b = '0;
    logic [31:0] r2_b = '0;
    logic        in_rdy_b = 1'b0;
    logic        busy2, ordy2, hit2, app2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    coll_det_param #(.W(16), .D(2), .FUTURE_ONLY(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .p1(p1_a), .p2(p2_a), .v1(v1_a), .v2(v2_a),
        .r2(r2_a), .in_rdy(in_rdy_a), .busy(busy0), .out_rdy(ordy0), .hit(hit0),
        .approaching(app0));

    coll_det_param #(.W(16), .D(2), .FUTURE_ONLY(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .p1(p1_a), .p2(p2_a), .v1(v1_a), .v2(v2_a),
        .r2(r2_a), .in_rdy(in_rdy_a), .busy(busy1), .out_rdy(ordy1), .hit(hit1),
        .approaching(app1));

    coll_det_param #(.W(32), .D(3), .FUTURE_ONLY(1'b0)) u_dut2 (
        .clock(clock), .reset(reset), .p1(p1_b), .p2(p2_b), .v1(v1_b), .v2(v2_b),
        .r2(r2_b), .in_rdy(in_rdy_b), .busy(busy2), .out_rdy(ordy2), .hit(hit2),
        .approaching(app2));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed field k of width w from a packed vector
    function automatic longint fld(input logic [95:0] v, input int k, input int w);
        logic [95:0] s;
        longint      x;
        s = v >> (k * w);
        x = 0;
        for (int b = 0; b < w; b++) x[b] = s[b];
        if (s[w-1]) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    // Closest approach of |dp + dv*t|^2 against r2, scaled by vrel2 to stay integral.
    // Returns {hit, approaching}.
    function automatic logic [1:0] ref_model(input int d, input int w, input bit fo,
                                             input logic [95:0] a1, input logic [95:0] a2,
                                             input logic [95:0] b1, input logic [95:0] b2,
                                             input logic [31:0] rr);
        big_t dist2, vrel2, dot, dpb, dvb, r2b;
        bit   h;
        dist2 = '0;
        vrel2 = '0;
        dot   = '0;
        for (int k = 0; k < d; k++) begin
            dpb   = fld(a1, k, w) - fld(a2, k, w);
            dvb   = fld(b1, k, w) - fld(b2, k, w);
            dist2 = dist2 + dpb * dpb;
            vrel2 = vrel2 + dvb * dvb;
            dot   = dot + dpb * dvb;
        end
        r2b = '0;
        r2b[31:0] = rr;
        if (vrel2 == 0 || (fo && dot >= 0)) h = (dist2 < r2b);
        else h = ((dist2 * vrel2 - dot * dot) < r2b * vrel2);
        return {h, dot < 0};
    endfunction

    function automatic logic [31:0] pk2(input int x, input int y);
        return {y[15:0], x[15:0]};
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(1, 0) == 0) return 16'($urandom);
        else return 16'($urandom_range(40, 0) - 20);
    endfunction

    function automatic logic [31:0] rnd32();
        if ($urandom_range(3, 0) == 0) return $urandom;
        else return $urandom_range(2000, 0) - 32'd1000;
    endfunction

    // Wait (bounded) for the W=16 strobe; returns edges counted since the accept
    task automatic wait_strobe16(output int cnt);
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (!ordy0 && cnt < 40);
    endtask

    // One operation on the W=16 pair; expected values from constants or the model
    task automatic op16(input string tag, input logic [31:0] ip1, input logic [31:0] ip2,
                        input logic [31:0] iv1, input logic [31:0] iv2, input logic [15:0] ir2,
                        input bit use_model, input bit e_h0, input bit e_h1, input bit e_ap);
        logic [1:0] m0, m1;
        int cnt;
        if (use_model) begin
            m0 = ref_model(2, 16, 1'b0, {64'd0, ip1}, {64'd0, ip2}, {64'd0, iv1}, {64'd0, iv2}, {16'd0, ir2});
            m1 = ref_model(2, 16, 1'b1, {64'd0, ip1}, {64'd0, ip2}, {64'd0, iv1}, {64'd0, iv2}, {16'd0, ir2});
            e_h0 = m0[1];
            e_h1 = m1[1];
            e_ap = m0[0];
        end
        @(negedge clock);
        p1_a = ip1; p2_a = ip2; v1_a = iv1; v2_a = iv2; r2_a = ir2;
        in_rdy_a = 1'b1;
        @(posedge clock);
        #1;
        in_rdy_a = 1'b0;
        check_eq({tag, "_busy"}, busy0, 1'b1);
        wait_strobe16(cnt);
        check_eq({tag, "_lat"}, cnt, 11);
        check_eq({tag, "_rdy1"}, ordy1, 1'b1);
        check_eq({tag, "_idle"}, busy0, 1'b0);
        check_eq({tag, "_hit"}, hit0, e_h0);
        check_eq({tag, "_hit_fo"}, hit1, e_h1);
        check_eq({tag, "_app"}, app0, e_ap);
        check_eq({tag, "_app_fo"}, app1, e_ap);
        @(posedge clock);
        #1;
        check_eq({tag, "_pulse"}, ordy0, 1'b0);
        check_eq({tag, "_hold"}, hit0, e_h0);
    endtask

    // One operation on the W=32, D=3 instance against the model
    task automatic op32(input logic [95:0] ip1, input logic [95:0] ip2, input logic [95:0] iv1,
                        input logic [95:0] iv2, input logic [31:0] ir2);
        logic [1:0] m;
        int cnt;
        m = ref_model(3, 32, 1'b0, ip1, ip2, iv1, iv2, ir2);
        @(negedge clock);
        p1_b = ip1; p2_b = ip2; v1_b = iv1; v2_b = iv2; r2_b = ir2;
        in_rdy_b = 1'b1;
        @(posedge clock);
        #1;
        in_rdy_b = 1'b0;
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (!ordy2 && cnt < 40);
        check_eq("w32_lat", cnt, 14);
        check_eq("w32_hit", hit2, m[1]);
        check_eq("w32_app", app2, m[0]);
    endtask

    initial begin
        logic [31:0] bp1 [5], bp2 [5], bv1 [5], bv2 [5];
        logic [15:0] br2 [5];
        logic [1:0]  e0, e1;
        logic [95:0] q1, q2, q3, q4;
        int          cnt;
        int          strobes;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_rdy", ordy0, 1'b0);
        check_eq("rst_hit", hit0, 1'b0);
        check_eq("rst_app", app0, 1'b0);
        check_eq("rst_busy32", busy2, 1'b0);
        reset = 1'b0;

        // Directed cases
        op16("head_on", pk2(0, 0), pk2(10, 0), pk2(1, 0), pk2(-1, 0), 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        op16("near_miss", pk2(0, 0), pk2(10, 5), pk2(1, 0), pk2(-1, 0), 16'd16, 1'b0, 1'b0, 1'b0, 1'b1);
        op16("graze", pk2(0, 0), pk2(10, 4), pk2(1, 0), pk2(-1, 0), 16'd16, 1'b0, 1'b0, 1'b0, 1'b1);
        op16("still_hit", pk2(0, 0), pk2(1, 1), pk2(3, 3), pk2(3, 3), 16'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        op16("still_miss", pk2(0, 0), pk2(1, 1), pk2(3, 3), pk2(3, 3), 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op16("separating", pk2(0, 0), pk2(10, 0), pk2(-1, 0), pk2(1, 0), 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        op16("extreme", pk2(-32768, -32768), pk2(32767, 32767), pk2(0, 0), pk2(0, 0), 16'd65535,
             1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised W=16 operations
        for (int i = 0; i < 30; i++) begin
            op16("rnd16", {rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()},
                 {rnd16(), rnd16()}, ($urandom_range(1, 0) == 0) ? 16'($urandom) : 16'($urandom_range(300, 0)),
                 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back with in_rdy held high; the next vector is staged right after each accept
        for (int i = 0; i < 5; i++) begin
            bp1[i] = {rnd16(), rnd16()};
            bp2[i] = {rnd16(), rnd16()};
            bv1[i] = {rnd16(), rnd16()};
            bv2[i] = {rnd16(), rnd16()};
            br2[i] = 16'($urandom_range(400, 0));
        end
        @(negedge clock);
        p1_a = bp1[0]; p2_a = bp2[0]; v1_a = bv1[0]; v2_a = bv2[0]; r2_a = br2[0];
        in_rdy_a = 1'b1;
        @(posedge clock);
        #1;
        p1_a = bp1[1]; p2_a = bp2[1]; v1_a = bv1[1]; v2_a = bv2[1]; r2_a = br2[1];
        for (int i = 0; i < 5; i++) begin
            e0 = ref_model(2, 16, 1'b0, {64'd0, bp1[i]}, {64'd0, bp2[i]}, {64'd0, bv1[i]}, {64'd0, bv2[i]}, {16'd0, br2[i]});
            e1 = ref_model(2, 16, 1'b1, {64'd0, bp1[i]}, {64'd0, bp2[i]}, {64'd0, bv1[i]}, {64'd0, bv2[i]}, {16'd0, br2[i]});
            wait_strobe16(cnt);
            check_eq("b2b_lat", cnt, 11);
            check_eq("b2b_hit", hit0, e0[1]);
            check_eq("b2b_hit_fo", hit1, e1[1]);
            check_eq("b2b_app", app0, e0[0]);
            if (i < 4) begin
                @(posedge clock);
                #1;
                check_eq("b2b_accept", busy0, 1'b1);
                if (i + 2 < 5) begin
                    p1_a = bp1[i+2]; p2_a = bp2[i+2]; v1_a = bv1[i+2]; v2_a = bv2[i+2]; r2_a = br2[i+2];
                end
            end else begin
                in_rdy_a = 1'b0;
            end
        end

        // Reset in the middle of an operation, after a result that left hit/approaching high
        op16("pre_reset", pk2(0, 0), pk2(10, 0), pk2(1, 0), pk2(-1, 0), 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        p1_a = pk2(0, 0); p2_a = pk2(1, 1); v1_a = pk2(2, 2); v2_a = pk2(-2, -2); r2_a = 16'd9;
        in_rdy_a = 1'b1;
        @(posedge clock);
        #1;
        in_rdy_a = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_busy", busy0, 1'b0);
        check_eq("mid_rst_rdy", ordy0, 1'b0);
        check_eq("mid_rst_hit", hit0, 1'b0);
        check_eq("mid_rst_app", app0, 1'b0);
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (ordy0 || busy0) strobes++;
        end
        check_eq("mid_rst_quiet", strobes, 0);
        op16("post_reset", pk2(0, 0), pk2(10, 0), pk2(-1, 0), pk2(1, 0), 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);

        // W=32, D=3 against the wide model
        for (int i = 0; i < 25; i++) begin
            q1 = {rnd32(), rnd32(), rnd32()};
            q2 = {rnd32(), rnd32(), rnd32()};
            q3 = {rnd32(), rnd32(), rnd32()};
            q4 = {rnd32(), rnd32(), rnd32()};
            op32(q1, q2, q3, q4, ($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(2000000, 0)));
        end
        q1 = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        q2 = {32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff};
        op32(q1, q2, q2, q1, 32'hffff_ffff);
        op32(q1, q2, q1, q2, 32'hffff_ffff);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
